// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, byte-laned data memory between the
// CPU load/store unit (port 0) and a DMA/debug loader (port 1).
// Each cycle it grants at most one port and steers that port's address,
// lane enables and store data to the memory. The load data is aligned and
// extended as it is captured, so the response arrives on the requesting
// port one cycle after the grant.
module dmem_arbiter #(
    parameter int MAX_BURST = 4,  // 1..15 back-to-back grants while the other port waits
    parameter int P0_PRIO   = 1   // 1: port 0 preferred, 0: round-robin
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [1:0]  m0_size_i,
    input  logic        m0_unsigned_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [1:0]  m1_size_i,
    input  logic        m1_unsigned_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic [31:0] d_addr_o,
    output logic [31:0] d_wdata_o,
    output logic [3:0]  d_we_o,
    input  logic [31:0] d_rdata_i
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Burst counter value at which the waiting port is forced in.
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    // ------------------------------------------------------------------
    // Access decode helpers
    // ------------------------------------------------------------------

    // Half needs 2-byte alignment and word needs 4-byte alignment. Size 11
    // is never legal.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: f_misaligned = 1'b0;
            SIZE_HALF: f_misaligned = off[0];
            SIZE_WORD: f_misaligned = (off != 2'b00);
            default:   f_misaligned = 1'b1;
        endcase
    endfunction

    // Byte-lane write enables for a legal store.
    function automatic logic [3:0] f_lanes(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: f_lanes = 4'b0001 << off;
            SIZE_HALF: f_lanes = 4'b0011 << off;
            SIZE_WORD: f_lanes = 4'b1111;
            default:   f_lanes = 4'b0000;
        endcase
    endfunction

    // Store data is right-justified and is replicated so that every lane
    // the enables might select carries the right byte.
    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: f_wdata = {4{wdata[7:0]}};
            SIZE_HALF: f_wdata = {2{wdata[15:0]}};
            default:   f_wdata = wdata;
        endcase
    endfunction

    // Select the addressed lane(s) of the memory word, right-justify them,
    // then zero- or sign-extend.
    function automatic logic [31:0] f_load(input logic [1:0]  size,
                                           input logic        uns,
                                           input logic [1:0]  off,
                                           input logic [31:0] rdata);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        v_byte = rdata[{off, 3'b000} +: 8];
        v_half = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: f_load = {{24{~uns & v_byte[7]}}, v_byte};
            SIZE_HALF: f_load = {{16{~uns & v_half[15]}}, v_half};
            default:   f_load = rdata;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State and internal wires
    // ------------------------------------------------------------------
    port_e       r_last_gnt;
    logic [3:0]  r_burst_cnt;

    logic        r_m0_rvalid;
    logic [31:0] r_m0_rdata;
    logic        r_m0_err;
    logic        r_m1_rvalid;
    logic [31:0] r_m1_rdata;
    logic        r_m1_err;

    logic        w_gnt_valid;
    port_e       w_winner;
    logic        w_other_req;
    logic        w_gnt0;
    logic        w_gnt1;

    logic        w_sel_we;
    logic [1:0]  w_sel_size;
    logic        w_sel_uns;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_bad;
    logic [31:0] w_load_data;

    // Pick this cycle's winner. While rst_i is high no port is granted, so
    // nothing reaches the memory and no response is queued.
    always_comb begin
        // NOTE: every always_comb output gets a default first. A path that
        // leaves one unassigned would infer a latch.
        w_gnt_valid = 1'b0;
        w_winner    = PORT0;
        if (!rst_i) begin
            if (m0_req_i && m1_req_i) begin
                w_gnt_valid = 1'b1;
                if (r_burst_cnt == BURST_LAST) begin
                    w_winner = port_e'(~r_last_gnt);
                end else if (P0_PRIO != 0) begin
                    w_winner = PORT0;
                end else begin
                    w_winner = port_e'(~r_last_gnt);
                end
            end else if (m0_req_i) begin
                w_gnt_valid = 1'b1;
                w_winner    = PORT0;
            end else if (m1_req_i) begin
                w_gnt_valid = 1'b1;
                w_winner    = PORT1;
            end
        end
    end

    assign w_gnt0      = w_gnt_valid && (w_winner == PORT0);
    assign w_gnt1      = w_gnt_valid && (w_winner == PORT1);
    assign w_other_req = (w_winner == PORT0) ? m1_req_i : m0_req_i;
    assign m0_gnt_o    = w_gnt0;
    assign m1_gnt_o    = w_gnt1;

    // Route the winning port's request fields to the memory side.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_size  = SIZE_BYTE;
        w_sel_uns   = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        if (w_gnt0) begin
            w_sel_we    = m0_we_i;
            w_sel_size  = m0_size_i;
            w_sel_uns   = m0_unsigned_i;
            w_sel_addr  = m0_addr_i;
            w_sel_wdata = m0_wdata_i;
        end else if (w_gnt1) begin
            w_sel_we    = m1_we_i;
            w_sel_size  = m1_size_i;
            w_sel_uns   = m1_unsigned_i;
            w_sel_addr  = m1_addr_i;
            w_sel_wdata = m1_wdata_i;
        end
    end

    // Drive the memory. A misaligned or illegal access still uses the slot,
    // but it must not touch any lane.
    always_comb begin
        w_sel_bad   = w_gnt_valid && f_misaligned(w_sel_size, w_sel_addr[1:0]);
        d_addr_o    = w_sel_addr;
        d_wdata_o   = w_gnt_valid ? f_wdata(w_sel_size, w_sel_wdata) : 32'd0;
        d_we_o      = (w_gnt_valid && w_sel_we && !w_sel_bad) ?
                      f_lanes(w_sel_size, w_sel_addr[1:0]) : 4'b0000;
        w_load_data = (w_gnt_valid && !w_sel_we && !w_sel_bad) ?
                      f_load(w_sel_size, w_sel_uns, w_sel_addr[1:0], d_rdata_i) : 32'd0;
    end

    // Track the last granted port and how many back-to-back grants it has
    // taken while the other port was waiting. Idle cycles keep the state.
    always_ff @(posedge clk_i) begin
        // NOTE: state in always_ff is assigned only with <=, so every block
        // samples the values from before the edge, whatever the block order.
        if (rst_i) begin
            r_last_gnt  <= PORT1;
            r_burst_cnt <= 4'd0;
        end else if (w_gnt_valid) begin
            if ((w_winner == r_last_gnt) && w_other_req) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
            end else begin
                r_burst_cnt <= 4'd0;
            end
            r_last_gnt <= w_winner;
        end
    end

    // Register a one-cycle response on the port granted in the previous
    // cycle. Stores and errors return zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= 32'd0;
            r_m0_err    <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= 32'd0;
            r_m1_err    <= 1'b0;
        end else begin
            r_m0_rvalid <= w_gnt0;
            r_m0_err    <= w_gnt0 && w_sel_bad;
            r_m0_rdata  <= w_gnt0 ? w_load_data : 32'd0;
            r_m1_rvalid <= w_gnt1;
            r_m1_err    <= w_gnt1 && w_sel_bad;
            r_m1_rdata  <= w_gnt1 ? w_load_data : 32'd0;
        end
    end

    assign m0_rvalid_o = r_m0_rvalid;
    assign m0_rdata_o  = r_m0_rdata;
    assign m0_err_o    = r_m0_err;
    assign m1_rvalid_o = r_m1_rvalid;
    assign m1_rdata_o  = r_m1_rdata;
    assign m1_err_o    = r_m1_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. It provides a byte-laned memory, runs directed
// scenarios followed by random two-port traffic, and compares every cycle
// against a reference model built from byte arrays and integer arithmetic.
module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;
    localparam int P0_PRIO   = 1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;

    logic        req   [2];
    logic        we    [2];
    logic [1:0]  size  [2];
    logic        uns   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];

    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic [31:0] d_addr_o, d_wdata_o, d_rdata_i;
    logic [3:0]  d_we_o;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.MAX_BURST(MAX_BURST), .P0_PRIO(P0_PRIO)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .m0_req_i      (req[0]),
        .m0_we_i       (we[0]),
        .m0_size_i     (size[0]),
        .m0_unsigned_i (uns[0]),
        .m0_addr_i     (addr[0]),
        .m0_wdata_i    (wdata[0]),
        .m0_gnt_o      (m0_gnt_o),
        .m0_rvalid_o   (m0_rvalid_o),
        .m0_rdata_o    (m0_rdata_o),
        .m0_err_o      (m0_err_o),
        .m1_req_i      (req[1]),
        .m1_we_i       (we[1]),
        .m1_size_i     (size[1]),
        .m1_unsigned_i (uns[1]),
        .m1_addr_i     (addr[1]),
        .m1_wdata_i    (wdata[1]),
        .m1_gnt_o      (m1_gnt_o),
        .m1_rvalid_o   (m1_rvalid_o),
        .m1_rdata_o    (m1_rdata_o),
        .m1_err_o      (m1_err_o),
        .d_addr_o      (d_addr_o),
        .d_wdata_o     (d_wdata_o),
        .d_we_o        (d_we_o),
        .d_rdata_i     (d_rdata_i)
    );

    // Memory attached to the DUT: combinational read and byte-laned write.
    logic [31:0] dmem [256];
    logic        mem_clear = 1'b1;

    assign d_rdata_i = dmem[d_addr_o[9:2]];

    always @(posedge clk_i) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (d_we_o[i]) dmem[d_addr_o[9:2]][8*i +: 8] <= d_wdata_o[8*i +: 8];
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [1024];
    int          m_last;
    int          m_streak;
    logic        e_valid [2];
    logic        e_err   [2];
    logic [31:0] e_data  [2];
    logic [3:0]  obs_we;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=0x%08h exp=0x%08h", tag, $time, got, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    task automatic set_txn(input int p, input logic w, input logic [1:0] s,
                           input logic u, input logic [31:0] a, input logic [31:0] d);
        req[p]   = 1'b1;
        we[p]    = w;
        size[p]  = s;
        uns[p]   = u;
        addr[p]  = a;
        wdata[p] = d;
    endtask

    // Run one clock cycle. Inputs are already set at the falling edge.
    // Comb outputs are checked before the rising edge and the registered
    // response just after it. w returns the granted port, or -1 for none.
    task automatic do_cycle(input logic rst, output int w);
        int          n, a, off;
        logic        bad;
        logic [3:0]  x_we;
        logic [31:0] x_wd, v;
        rst_i = rst;
        #1;
        for (int p = 0; p < 2; p++) begin
            e_valid[p] = 1'b0;
            e_err[p]   = 1'b0;
            e_data[p]  = 32'd0;
        end
        if (rst)                       w = -1;
        else if (req[0] && req[1])     w = (m_streak == MAX_BURST - 1 || P0_PRIO == 0) ? 1 - m_last : 0;
        else if (req[0])               w = 0;
        else if (req[1])               w = 1;
        else                           w = -1;

        check("gnt0", 32'(m0_gnt_o), 32'(w == 0));
        check("gnt1", 32'(m1_gnt_o), 32'(w == 1));
        obs_we = d_we_o;

        if (w >= 0) begin
            n   = size_bytes(size[w]);
            a   = int'(addr[w][9:0]);
            off = a % 4;
            bad = (size[w] == 2'b11) || ((a % n) != 0);
            x_we = 4'b0000;
            for (int i = 0; i < 4; i++)
                if (we[w] && !bad && i >= off && i < off + n) x_we[i] = 1'b1;
            check("d_addr", d_addr_o, addr[w]);
            check("d_we", 32'(d_we_o), 32'(x_we));
            if (we[w] && !bad) begin
                for (int i = 0; i < 4; i++) x_wd[8*i +: 8] = wdata[w][8*(i % n) +: 8];
                check("d_wdata", d_wdata_o, x_wd);
                for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[w][8*i +: 8];
            end
            v = 32'd0;
            if (!we[w] && !bad) begin
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
                if (n < 4 && !uns[w] && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            end
            e_valid[w] = 1'b1;
            e_err[w]   = bad;
            e_data[w]  = v;
            if (w == m_last && req[1 - w]) m_streak++;
            else                           m_streak = 0;
            m_last = w;
        end else begin
            check("d_addr_idle", d_addr_o, 32'd0);
            check("d_we_idle", 32'(d_we_o), 32'd0);
            if (rst) check("d_wdata_rst", d_wdata_o, 32'd0);
        end
        if (rst) begin
            m_last   = 1;
            m_streak = 0;
        end

        @(posedge clk_i);
        #1;
        check("rvalid0", 32'(m0_rvalid_o), 32'(e_valid[0]));
        check("err0",    32'(m0_err_o),    32'(e_err[0]));
        check("rdata0",  m0_rdata_o,       e_data[0]);
        check("rvalid1", 32'(m1_rvalid_o), 32'(e_valid[1]));
        check("err1",    32'(m1_err_o),    32'(e_err[1]));
        check("rdata1",  m1_rdata_o,       e_data[1]);
        @(negedge clk_i);
    endtask

    int burst_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        int w, r, n, a;
        logic [1:0] s;
        logic rst;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        m_last   = 1;
        m_streak = 0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; size[p] = 2'b00;
            uns[p] = 1'b0; addr[p] = 32'd0; wdata[p] = 32'd0;
        end

        // Reset: no grants, memory side idle, responses cleared
        @(negedge clk_i);
        do_cycle(1'b1, w);
        do_cycle(1'b1, w);
        mem_clear = 1'b0;
        do_cycle(1'b0, w);

        // 1: word store then word load
        set_txn(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        do_cycle(1'b0, w);
        check("t1_we", 32'(obs_we), 32'h0000000F);
        set_txn(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        do_cycle(1'b0, w);
        check("t1_rvalid", 32'(m0_rvalid_o), 32'd1);
        check("t1_rdata", m0_rdata_o, 32'hDEADBEEF);

        // 2: byte store at lane 3, signed and unsigned byte loads
        set_txn(0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5);
        do_cycle(1'b0, w);
        check("t2_we", 32'(obs_we), 32'h00000008);
        set_txn(0, 1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
        do_cycle(1'b0, w);
        check("t2_signed", m0_rdata_o, 32'hFFFFFFA5);
        set_txn(0, 1'b0, 2'b00, 1'b1, 32'h103, 32'd0);
        do_cycle(1'b0, w);
        check("t2_unsigned", m0_rdata_o, 32'h000000A5);

        // 3: signed half load from the upper lane pair
        set_txn(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h80011234);
        do_cycle(1'b0, w);
        set_txn(0, 1'b0, 2'b01, 1'b0, 32'h102, 32'd0);
        do_cycle(1'b0, w);
        check("t3_half", m0_rdata_o, 32'hFFFF8001);

        // 4: misaligned word store is granted, writes nothing, reports err
        set_txn(0, 1'b1, 2'b10, 1'b0, 32'h102, 32'h55555555);
        do_cycle(1'b0, w);
        check("t4_gnt", 32'(w), 32'd0);
        check("t4_we", 32'(obs_we), 32'd0);
        check("t4_err", 32'(m0_err_o), 32'd1);
        set_txn(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        do_cycle(1'b0, w);
        check("t4_unchanged", m0_rdata_o, 32'h80011234);
        req[0] = 1'b0;

        // 5: both ports held, burst limit forces port 1 in every fifth grant
        do_cycle(1'b1, w);
        set_txn(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
        set_txn(1, 1'b0, 2'b10, 1'b0, 32'h80, 32'd0);
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b0, w);
            check($sformatf("t5_seq%0d", k), 32'(w), 32'(burst_exp[k]));
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        do_cycle(1'b0, w);

        // 6: reset during the grant cycle of a port 1 store
        set_txn(1, 1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344);
        do_cycle(1'b0, w);
        set_txn(1, 1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D);
        do_cycle(1'b1, w);
        check("t6_we", 32'(obs_we), 32'd0);
        check("t6_rvalid", 32'(m1_rvalid_o), 32'd0);
        set_txn(1, 1'b0, 2'b10, 1'b0, 32'h200, 32'd0);
        do_cycle(1'b0, w);
        check("t6_unchanged", m1_rdata_o, 32'h11223344);
        req[1] = 1'b0;

        // Random two-port traffic with withdrawals and occasional resets
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p] && $urandom_range(0, 2) != 0) begin
                    r = int'($urandom_range(0, 7));
                    s = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
                    n = size_bytes(s);
                    a = int'($urandom_range(0, 1023));
                    if ($urandom_range(0, 1) == 1) a = a - (a % n);
                    set_txn(p, 1'(($urandom_range(0, 1))), s, 1'(($urandom_range(0, 1))),
                            {22'($urandom_range(0, 3)), 10'(a)}, $urandom());
                end else if (req[p] && $urandom_range(0, 15) == 0) begin
                    req[p] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 63) == 0);
            do_cycle(rst, w);
            if (w >= 0) req[w] = 1'b0;
        end

        req[0] = 1'b0;
        req[1] = 1'b0;
        do_cycle(1'b0, w);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
